// File: rtl/img_feed_pkg.sv
// Shared constants for the image column path: default pixel width, column width
// and the byte-lane placement of the three rows inside a column word.
package img_feed_pkg;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_COL_W = 3 * DEF_PIX_W;

  // Lane index of each row inside a column word (lane 0 is the LSBs).
  localparam int unsigned LANE_BOT = 0;  // current row
  localparam int unsigned LANE_MID = 1;  // row-1
  localparam int unsigned LANE_TOP = 2;  // row-2

  // Bit offset of a lane for a given pixel width.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned pix_w);
    return lane * pix_w;
  endfunction

endpackage

// File: rtl/line_mem.sv
// Single row line memory: combinational read and clocked write at the same address,
// so a read in the write cycle returns the previous contents.
//   clk      clock
//   we       write enable
//   addr     shared read/write address (column index)
//   wdata    write data
//   rdata_c  read data (combinational, old contents)
module line_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the consumer masks rows that are not yet written.
  assign rdata_c = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/img_col_feeder.sv
// Raster-to-column converter: for each accepted pixel emits {row-2, row-1, row}
// at the same column, one cycle later, with window/row/frame qualifiers.
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous restart of the frame at (0,0)
//   pix_in/pix_valid/pix_ready   raster pixel input handshake
//   col_out/col_valid/out_ready  column output handshake
//   win_valid         column completes a full 3x3 window (row>=2, col>=2)
//   row_last          column is the last of its row
//   frame_done        one-cycle pulse when the last pixel of the frame is accepted
module img_col_feeder
  import img_feed_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [3*PIX_W-1:0] col_out,
  output logic               col_valid,
  input  logic               out_ready,
  output logic               win_valid,
  output logic               row_last,
  output logic               frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0]      col_cnt;
  logic [RW-1:0]      row_cnt;
  logic               accept;
  logic               col_end;
  logic               row_end;
  logic [PIX_W-1:0]   lb0_rd_c;
  logic [PIX_W-1:0]   lb1_rd_c;
  logic [PIX_W-1:0]   top_pix;
  logic [PIX_W-1:0]   mid_pix;
  logic [3*PIX_W-1:0] col_next;

  // A held output blocks new pixels; flush drops whatever is presented.
  assign pix_ready = !flush && (!col_valid || out_ready);
  assign accept    = pix_valid && pix_ready;
  assign col_end   = (col_cnt == CW'(IMG_W - 1));
  assign row_end   = (row_cnt == RW'(IMG_H - 1));

  // lb0 holds row-1, lb1 holds row-2; lb1 takes lb0's old word as lb0 takes the pixel.
  line_mem #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (col_cnt),
    .wdata   (pix_in),
    .rdata_c (lb0_rd_c)
  );

  line_mem #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (col_cnt),
    .wdata   (lb0_rd_c),
    .rdata_c (lb1_rd_c)
  );

  // Rows above the top of the frame read as zero, hiding stale line memory contents.
  assign top_pix = (row_cnt >= RW'(2)) ? lb1_rd_c : '0;
  assign mid_pix = (row_cnt != '0)     ? lb0_rd_c : '0;

  // Pack the column word by lane.
  always_comb begin
    col_next = '0;
    col_next[lane_lsb(LANE_TOP, PIX_W) +: PIX_W] = top_pix;
    col_next[lane_lsb(LANE_MID, PIX_W) +: PIX_W] = mid_pix;
    col_next[lane_lsb(LANE_BOT, PIX_W) +: PIX_W] = pix_in;
  end

  // Position counters and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      col_out    <= '0;
      col_valid  <= 1'b0;
      win_valid  <= 1'b0;
      row_last   <= 1'b0;
      frame_done <= 1'b0;
    end else if (flush) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      col_valid  <= 1'b0;
      win_valid  <= 1'b0;
      row_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        col_out    <= col_next;
        col_valid  <= 1'b1;
        win_valid  <= (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
        row_last   <= col_end;
        frame_done <= col_end && row_end;
        if (col_end) begin
          col_cnt <= '0;
          row_cnt <= row_end ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end else if (out_ready) begin
        col_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_img_col_feeder.sv
// Bench for img_col_feeder at IMG_W=4, IMG_H=4: a frame-level reference model checked
// every cycle, plus directed scenarios with hand-computed column values.
module tb_img_col_feeder;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst, flush, pix_valid, out_ready;
  logic [7:0]  pix_in;
  logic        pix_ready, col_valid, win_valid, row_last, frame_done;
  logic [23:0] col_out;

  int n_tests = 0;
  int n_fail  = 0;

  img_col_feeder #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .col_out    (col_out),
    .col_valid  (col_valid),
    .out_ready  (out_ready),
    .win_valid  (win_valid),
    .row_last   (row_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // Reference model: remembers the current frame's pixels by (row, col); the column for a
  // pixel is the two pixels directly above it in this frame, zero above the top edge.
  typedef struct packed {
    logic [23:0] col;
    logic        win;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] img [H][W];
  int         mpos     = 0;
  logic       fd_exp   = 1'b0;
  logic       zero_chk = 1'b0;
  logic       armed    = 1'b0;

  always @(negedge clk) begin : model
    int   r, c;
    exp_t e;
    if (armed) begin
      check("pix_ready", 32'(pix_ready), 32'(!flush && (!col_valid || out_ready)));
      check("col_valid", 32'(col_valid), 32'(exp_q.size() != 0));
      if (col_valid && exp_q.size() != 0) begin
        check("col_out",   32'(col_out),   32'(exp_q[0].col));
        check("win_valid", 32'(win_valid), 32'(exp_q[0].win));
        check("row_last",  32'(row_last),  32'(exp_q[0].last));
      end
      check("frame_done", 32'(frame_done), 32'(fd_exp));
      if (zero_chk) check("rst_col_out", 32'(col_out), 32'h0);
    end
    zero_chk = 1'b0;
    fd_exp   = 1'b0;
    if (rst) begin
      exp_q.delete();
      mpos     = 0;
      zero_chk = 1'b1;
      armed    = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      mpos = 0;
    end else if (armed) begin
      if (col_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (pix_valid && pix_ready) begin
        r = mpos / W;
        c = mpos % W;
        e.col  = {(r >= 2) ? img[r-2][c] : 8'h00, (r >= 1) ? img[r-1][c] : 8'h00, pix_in};
        e.win  = (r >= 2) && (c >= 2);
        e.last = (c == W - 1);
        exp_q.push_back(e);
        img[r][c] = pix_in;
        fd_exp    = (mpos == W * H - 1);
        mpos      = (mpos + 1) % (W * H);
      end
    end
  end

  // Present one pixel and wait for it to be accepted; returns cycles spent.
  task automatic send(input logic [7:0] p, output int n);
    logic acc;
    n = 0;
    pix_in    = p;
    pix_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: pixel 0x%0h not accepted in %0d cycles", p, n);
    end
    pix_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [23:0] col, input logic win, input logic last);
    check({nm, "_valid"}, 32'(col_valid), 32'h1);
    check({nm, "_col"},   32'(col_out),   32'(col));
    check({nm, "_win"},   32'(win_valid), 32'(win));
    check({nm, "_last"},  32'(row_last),  32'(last));
  endtask

  task automatic send_range(input int lo, input int hi);
    int n;
    for (int i = lo; i <= hi; i++) send(8'(i), n);
  endtask

  // One frame of pixels 4r+c with hand-computed columns and flags.
  task automatic frame_directed();
    int n;
    for (int i = 0; i < W * H; i++) begin
      send(8'(i), n);
      case (i)
        2:  lit("p2",  24'h000002, 1'b0, 1'b0);
        3:  lit("p3",  24'h000003, 1'b0, 1'b1);
        6:  lit("p6",  24'h000206, 1'b0, 1'b0);
        7:  lit("p7",  24'h000307, 1'b0, 1'b1);
        9:  lit("p9",  24'h010509, 1'b0, 1'b0);
        10: lit("p10", 24'h02060A, 1'b1, 1'b0);
        11: lit("p11", 24'h03070B, 1'b1, 1'b1);
        14: check("p14_frame_done", 32'(frame_done), 32'h0);
        15: begin
          lit("p15", 24'h070B0F, 1'b1, 1'b1);
          check("p15_frame_done", 32'(frame_done), 32'h1);
        end
        default: ;
      endcase
    end
  endtask

  initial begin : stim
    int n;
    int acc;
    rst = 1'b1; flush = 1'b0; pix_valid = 1'b0; out_ready = 1'b1; pix_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_col_valid",  32'(col_valid),  32'h0);
    check("rst_win_valid",  32'(win_valid),  32'h0);
    check("rst_row_last",   32'(row_last),   32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_col_out",    32'(col_out),    32'h0);
    rst = 1'b0;

    // Streaming, flags, and the masked frame wrap.
    frame_directed();
    send(8'h20, n);
    lit("wrap", 24'h000020, 1'b0, 1'b0);
    check("wrap_frame_done", 32'(frame_done), 32'h0);
    send_range(1, 15);

    // Backpressure after pixel 5.
    send_range(0, 5);
    lit("bp_p5", 24'h000105, 1'b0, 1'b0);
    out_ready = 1'b0; pix_in = 8'd6; pix_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_hold_col",   32'(col_out),   32'h000105);
      check("bp_hold_valid", 32'(col_valid), 32'h1);
      check("bp_hold_ready", 32'(pix_ready), 32'h0);
    end
    out_ready = 1'b1;
    send(8'd6, n);
    check("bp_latency", 32'(n), 32'h1);
    lit("bp_p6", 24'h000206, 1'b0, 1'b0);
    send_range(7, 15);

    // Flush while pixel 9 is presented.
    send_range(0, 8);
    pix_in = 8'd9; pix_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; pix_valid = 1'b0;
    check("flush_col_valid",  32'(col_valid),  32'h0);
    check("flush_frame_done", 32'(frame_done), 32'h0);
    send(8'h55, n);
    lit("flush_restart", 24'h000055, 1'b0, 1'b0);
    send_range(1, 15);

    // Reset in the middle of row 2, then a clean frame.
    send_range(0, 9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_col_out",    32'(col_out),    32'h0);
    check("mid_rst_col_valid",  32'(col_valid),  32'h0);
    check("mid_rst_win_valid",  32'(win_valid),  32'h0);
    check("mid_rst_row_last",   32'(row_last),   32'h0);
    check("mid_rst_frame_done", 32'(frame_done), 32'h0);
    frame_directed();

    // Random valid/ready gaps over three frames, checked by the model.
    acc = 0;
    for (int cyc = 0; cyc < 3000 && acc < 3 * W * H; cyc++) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      pix_in    = 8'($urandom);
      @(negedge clk);
      if (pix_valid && pix_ready) acc++;
      @(posedge clk);
      #1;
    end
    check("rand_accepts", 32'(acc), 32'(3 * W * H));
    pix_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
